// File: rtl/pl_run_controller.sv
// Purpose : sequences one program run of the pipeline CPU (reset, run, drain) and counts run statistics.
// Latency : every output comes straight from a flop or from the registered state; inputs act on the next clock edge.
// Backpress: none; start is ignored outside IDLE/DONE, and abort ends the run from RST, RUN or DRAIN.
//
// Ports
//   input_clk                 single clock, rising edge
//   rst                       asynchronous active-low reset
//   start                     begin or restart a run (IDLE/DONE only)
//   abort                     cancel the run and return to IDLE
//   hlt_retired               hlt reached writeback; ends RUN
//   stall                     stall bubble inserted this cycle
//   branch_valid/branch_miss  branch resolved / mispredicted (miss qualified by valid)
//   cpu_rst, cpu_clk_en       pipeline reset (active high) and clock enable
//   cycles_consumed, StallCount, BranchPredictionCount, BranchPredictionMissCount
//                             saturating 32-bit run statistics
//   done, timeout             run finished; run ended by cycle budget instead of hlt
//   state                     IDLE=0 RST=1 RUN=2 DRAIN=3 DONE=4
module pl_run_controller #(
   parameter int RESET_CYCLES = 4,
   parameter int MAX_CLOCKS   = 100000,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic        input_clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        hlt_retired,
   input  logic        stall,
   input  logic        branch_valid,
   input  logic        branch_miss,
   output logic        cpu_rst,
   output logic        cpu_clk_en,
   output logic [31:0] cycles_consumed,
   output logic [31:0] StallCount,
   output logic [31:0] BranchPredictionCount,
   output logic [31:0] BranchPredictionMissCount,
   output logic        done,
   output logic        timeout,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RST   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // Last value of the shared sub-counter in RST/DRAIN, and the cycle count
   // at which a non-halting RUN cycle exhausts the budget.
   localparam logic [31:0] RST_LAST   = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
   localparam logic [31:0] TMO_AT     = 32'(MAX_CLOCKS - 1);

   state_e      state_q, state_d;
   logic [31:0] sub_q, sub_d;
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] stl_q, stl_d;
   logic [31:0] br_q, br_d;
   logic [31:0] miss_q, miss_d;
   logic        tmo_q, tmo_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      cyc_d   = cyc_q;
      stl_d   = stl_q;
      br_d    = br_q;
      miss_d  = miss_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RST;
               sub_d   = '0;
               cyc_d   = '0;
               stl_d   = '0;
               br_d    = '0;
               miss_d  = '0;
               tmo_d   = 1'b0;
            end
         end
         S_RST: begin
            if (abort) begin
               state_d = S_IDLE;
               sub_d   = '0;
            end else if (sub_q == RST_LAST) begin
               state_d = S_RUN;
               sub_d   = '0;
            end else begin
               sub_d = sub_q + 32'd1;
            end
         end
         S_RUN: begin
            // abort discards this cycle entirely: no events are counted.
            if (abort) begin
               state_d = S_IDLE;
               sub_d   = '0;
            end else begin
               if (stall)                       stl_d  = sat_inc(stl_q);
               if (branch_valid)                br_d   = sat_inc(br_q);
               if (branch_valid && branch_miss) miss_d = sat_inc(miss_q);
               if (hlt_retired) begin
                  // The hlt cycle itself is not a consumed cycle, and hlt
                  // beats a coincident budget expiry.
                  state_d = S_DRAIN;
                  sub_d   = '0;
               end else begin
                  cyc_d = sat_inc(cyc_q);
                  if (cyc_q == TMO_AT) begin
                     tmo_d   = 1'b1;
                     state_d = S_DRAIN;
                     sub_d   = '0;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d = S_IDLE;
               sub_d   = '0;
            end else if (sub_q == DRAIN_LAST) begin
               state_d = S_DONE;
               sub_d   = '0;
            end else begin
               sub_d = sub_q + 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            sub_d   = '0;
         end
      endcase
   end

   always_ff @(posedge input_clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sub_q   <= '0;
         cyc_q   <= '0;
         stl_q   <= '0;
         br_q    <= '0;
         miss_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         cyc_q   <= cyc_d;
         stl_q   <= stl_d;
         br_q    <= br_d;
         miss_q  <= miss_d;
         tmo_q   <= tmo_d;
      end
   end

   // Pipeline controls are pure decodes of the state register; any
   // unexpected encoding holds the CPU in reset with its clock stopped.
   assign cpu_rst    = !((state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_DONE));
   assign cpu_clk_en = (state_q == S_RST) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done       = (state_q == S_DONE);
   assign timeout    = tmo_q;
   assign state      = state_q;

   assign cycles_consumed           = cyc_q;
   assign StallCount                = stl_q;
   assign BranchPredictionCount     = br_q;
   assign BranchPredictionMissCount = miss_q;

endmodule

// File: doc/pl_run_controller.md
PL_RUN_CONTROLLER -- requirements
Module: pl_run_controller

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4, giving the number of clocks cpu_rst is held high after start.
REQ-002 SHALL have parameter MAX_CLOCKS, default 100000, giving the RUN-state cycle budget before timeout.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, giving the number of clocks the pipeline keeps running after halt.
REQ-004 SHALL have port input_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin (or restart) a program run.
REQ-007 SHALL have port abort, input, 1 bit: cancel the run and return to IDLE.
REQ-008 SHALL have port hlt_retired, input, 1 bit: hlt instruction reached writeback this cycle.
REQ-009 SHALL have port stall, input, 1 bit: the CPU stall-detection unit inserted a bubble this cycle.
REQ-010 SHALL have port branch_valid, input, 1 bit: a predicted branch was resolved this cycle.
REQ-011 SHALL have port branch_miss, input, 1 bit: the resolved branch was mispredicted; qualified by branch_valid.
REQ-012 SHALL have port cpu_rst, output, 1 bit: active-high reset to the pipeline CPU.
REQ-013 SHALL have port cpu_clk_en, output, 1 bit: pipeline clock enable.
REQ-014 SHALL have port cycles_consumed, output, 32 bits: RUN cycles counted.
REQ-015 SHALL have port StallCount, output, 32 bits: stall cycles counted.
REQ-016 SHALL have port BranchPredictionCount, output, 32 bits: resolved branches counted.
REQ-017 SHALL have port BranchPredictionMissCount, output, 32 bits: mispredictions counted.
REQ-018 SHALL have port done, output, 1 bit: run finished, counters final.
REQ-019 SHALL have port timeout, output, 1 bit: run ended by MAX_CLOCKS rather than hlt.
REQ-020 SHALL have port state, output, 3 bits: current state (IDLE=0, RST=1, RUN=2, DRAIN=3, DONE=4).

Function
REQ-021 SHALL implement states IDLE, RST, RUN, DRAIN, DONE; unused encodings SHALL return to IDLE next clock.
REQ-022 IDLE: cpu_rst=1, cpu_clk_en=0, done=0, counters hold; start=1 -> RST next clock, all four counters and timeout cleared on the same edge.
REQ-023 RST: cpu_rst=1, cpu_clk_en=1 for exactly RESET_CYCLES clocks, then -> RUN; start and hlt_retired ignored.
REQ-024 RUN: cpu_rst=0, cpu_clk_en=1; each cycle cycles_consumed +1 unless hlt_retired=1 (the hlt cycle is not counted).
REQ-025 RUN: StallCount +1 when stall=1; BranchPredictionCount +1 when branch_valid=1; BranchPredictionMissCount +1 when branch_valid=1 and branch_miss=1; branch_miss with branch_valid=0 ignored.
REQ-026 RUN: hlt_retired=1 -> DRAIN; the stall/branch events of that same cycle are still counted.
REQ-027 RUN: when cycles_consumed equals MAX_CLOCKS-1 and hlt_retired=0, SHALL count that cycle, set timeout=1, go -> DRAIN; hlt_retired wins when both occur in the same cycle (timeout stays 0).
REQ-028 DRAIN: cpu_clk_en=1, cpu_rst=0, counters frozen, for DRAIN_CYCLES clocks, then -> DONE.
REQ-029 DONE: done=1, cpu_clk_en=0, cpu_rst=0, counters and timeout hold; start=1 -> RST with counters and timeout cleared.
REQ-030 abort=1 in RST, RUN or DRAIN SHALL -> IDLE next clock; counters hold their values; abort has priority over hlt_retired and timeout.
REQ-031 Every counter SHALL saturate at 0xFFFFFFFF, never wrapping.
REQ-032 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-033 rst=0 SHALL immediately, regardless of clock, force state=IDLE, cpu_rst=1, cpu_clk_en=0, done=0, timeout=0, all counters=0, RST/DRAIN sub-counters=0.
REQ-034 Deasserting rst SHALL leave the block in IDLE until start; rst asserted mid-RUN SHALL discard the run.

Verification
REQ-035 Start pulse, hlt_retired after 20 RUN cycles -> cpu_rst high for 4 clocks, cycles_consumed=20, DRAIN 4 clocks, done=1, timeout=0.
REQ-036 In RUN: stall on 3 cycles, branch_valid on 5 cycles with branch_miss on 2 of them plus 1 cycle with branch_miss only -> StallCount=3, BranchPredictionCount=5, BranchPredictionMissCount=2.
REQ-037 MAX_CLOCKS=16, hlt_retired never asserted -> cycles_consumed=16, timeout=1, done=1 after 4 DRAIN clocks; repeat with hlt_retired on the 16th cycle -> timeout=0, cycles_consumed=15.
REQ-038 abort in RUN at cycle 7 -> state=IDLE next clock, cpu_rst=1, cycles_consumed=7 held; rst=0 at cycle 7 instead -> immediate IDLE, all counters 0.
REQ-039 Counters preloaded near 0xFFFFFFFF via force -> saturate at 0xFFFFFFFF; start from DONE -> all counters 0 and RST entered.
